// File: rtl/entropy_decode_ac_level_coefficients.sv
// rtl/entropy_decode_ac_level_coefficients.sv - ProRes AC level VLC decoder with adaptive codebook
module entropy_decode_ac_level_coefficients #(
    parameter int WINDOW = 48,
    parameter int LEN_W  = 6
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [WINDOW-1:0]   in_window,
    input  logic                block_start,
    input  logic                in_valid,
    output logic                in_ready,
    output logic signed [31:0]  out_level,
    output logic [LEN_W-1:0]    out_length,
    output logic                out_error,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int ZW = $clog2(WINDOW + 1);
    localparam int LW = ZW + 2;

    typedef enum logic [1:0] {S_IDLE, S_LZC, S_DEC, S_OUT} state_t;

    state_t              state_q, state_d;
    logic [WINDOW-1:0]   win_q, win_d;
    logic                bs_q, bs_d;
    logic [3:0]          prev_q, prev_d;
    logic [ZW-1:0]       z_q, z_d;
    logic [31:0]         n_q, n_d;
    logic [LW-1:0]       len_q, len_d;
    logic                err_q, err_d;
    logic signed [31:0]  out_level_q, out_level_d;
    logic [LEN_W-1:0]    out_length_q, out_length_d;
    logic                out_error_q, out_error_d;
    logic                out_valid_q, out_valid_d;

    logic [3:0]          p;
    logic [1:0]          t_cb, k_cb;
    logic [LW-1:0]       z_ext, t_ext, k_ext, w, amt, dec_len;
    logic [WINDOW-1:0]   shifted, sgn_mask;
    logic [31:0]         m, dec_n, mag;
    logic                dec_err, sgn;

    function automatic logic [ZW-1:0] lzc(input logic [WINDOW-1:0] v);
        lzc = ZW'(WINDOW);
        for (int i = 0; i < WINDOW; i++) begin
            if (v[i]) lzc = ZW'(WINDOW - 1 - i);
        end
    endfunction

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        bs_d         = bs_q;
        prev_d       = prev_q;
        z_d          = z_q;
        n_d          = n_q;
        len_d        = len_q;
        err_d        = err_q;
        out_level_d  = out_level_q;
        out_length_d = out_length_q;
        out_error_d  = out_error_q;
        out_valid_d  = out_valid_q;

        p = bs_q ? 4'd1 : prev_q;
        case (p)
            4'd0:                      begin t_cb = 2'd3; k_cb = 2'd2; end
            4'd1:                      begin t_cb = 2'd2; k_cb = 2'd1; end
            4'd2:                      begin t_cb = 2'd3; k_cb = 2'd1; end
            4'd3:                      begin t_cb = 2'd0; k_cb = 2'd0; end
            4'd4, 4'd5, 4'd6, 4'd7:    begin t_cb = 2'd0; k_cb = 2'd1; end
            default:                   begin t_cb = 2'd0; k_cb = 2'd2; end
        endcase

        z_ext   = LW'(z_q);
        t_ext   = LW'(t_cb);
        k_ext   = LW'(k_cb);
        w       = z_ext - t_ext + k_ext;
        // Left-align the leading one, then keep the top w+1 bits as the exp-Golomb value m.
        shifted = win_q << z_q;
        amt     = (w < LW'(WINDOW)) ? (LW'(WINDOW - 1) - w) : '0;
        m       = 32'(shifted >> amt);
        if (z_ext < t_ext) begin
            dec_n   = 32'(z_q);
            dec_len = z_ext + LW'(1);
        end else begin
            dec_n   = 32'(t_cb) + m - (32'd1 << k_cb);
            dec_len = z_ext + w + LW'(1);
        end
        dec_err = (z_q == ZW'(WINDOW)) || (dec_len >= LW'(WINDOW));

        sgn_mask = {1'b1, {(WINDOW-1){1'b0}}} >> len_q;
        sgn      = |(win_q & sgn_mask);
        mag      = n_q + 32'd1;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    win_d   = in_window;
                    bs_d    = block_start;
                    state_d = S_LZC;
                end
            end
            S_LZC: begin
                z_d     = lzc(win_q);
                state_d = S_DEC;
            end
            S_DEC: begin
                n_d     = dec_n;
                len_d   = dec_len;
                err_d   = dec_err;
                // Only the >=8 class matters for codebook choice, so saturate the history.
                if (!dec_err) prev_d = (dec_n >= 32'd8) ? 4'd8 : dec_n[3:0];
                state_d = S_OUT;
            end
            S_OUT: begin
                if (!out_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_error_d  = err_q;
                    out_level_d  = err_q ? 32'sd0 : (sgn ? -$signed(mag) : $signed(mag));
                    out_length_d = err_q ? '0 : LEN_W'(len_q + LW'(1));
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            win_q        <= '0;
            bs_q         <= 1'b0;
            prev_q       <= 4'd1;
            z_q          <= '0;
            n_q          <= '0;
            len_q        <= '0;
            err_q        <= 1'b0;
            out_level_q  <= '0;
            out_length_q <= '0;
            out_error_q  <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            bs_q         <= bs_d;
            prev_q       <= prev_d;
            z_q          <= z_d;
            n_q          <= n_d;
            len_q        <= len_d;
            err_q        <= err_d;
            out_level_q  <= out_level_d;
            out_length_q <= out_length_d;
            out_error_q  <= out_error_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_level  = out_level_q;
    assign out_length = out_length_q;
    assign out_error  = out_error_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_entropy_decode_ac_level_coefficients.sv
// tb/tb_entropy_decode_ac_level_coefficients.sv - table-driven scoreboard bench for the AC level decoder
module tb_entropy_decode_ac_level_coefficients;

    localparam int WINDOW = 48;
    localparam int LEN_W  = 6;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [WINDOW-1:0]   in_window = '0;
    logic                block_start = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [31:0]  out_level;
    logic [LEN_W-1:0]    out_length;
    logic                out_error;
    logic                out_valid;
    logic                out_ready = 1'b1;

    entropy_decode_ac_level_coefficients #(.WINDOW(WINDOW), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset_n(reset_n), .in_window(in_window), .block_start(block_start),
        .in_valid(in_valid), .in_ready(in_ready), .out_level(out_level),
        .out_length(out_length), .out_error(out_error), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] win;
        bit          bs;
        int          level;
        int          len;
        bit          err;
        int          hold;
    } vec_t;

    typedef struct {
        int level;
        int len;
        bit err;
    } exp_t;

    exp_t sb[$];
    vec_t tv[14];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [47:0] msb(input logic [47:0] b, input int nb);
        return b << (48 - nb);
    endfunction

    function automatic vec_t mk(input logic [47:0] w, input bit bs, input int lvl,
                                input int len, input bit err, input int hold);
        vec_t v;
        v.win = w; v.bs = bs; v.level = lvl; v.len = len; v.err = err; v.hold = hold;
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic send(input logic [47:0] w, input bit bs, input int lvl,
                        input int len, input bit err, input int hold);
        int   cyc;
        exp_t e;
        @(negedge clk);
        in_window   = w;
        block_start = bs;
        in_valid    = 1'b1;
        out_ready   = (hold == 0);
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!in_ready) begin
            timeout("accept");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        in_window   = {$urandom, $urandom};
        block_start = 1'($urandom_range(1));
        e.level = lvl; e.len = len; e.err = err;
        sb.push_back(e);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!out_valid) begin
            timeout("out_valid");
            void'(sb.pop_front());
            out_ready = 1'b1;
            return;
        end
        chk("latency", cyc, 3);
        e = sb.pop_front();
        chk("level", out_level, e.level);
        chk("length", out_length, e.len);
        chk("error", out_error, e.err);
        chk("in_ready_busy", in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_level", out_level, e.level);
            chk("hold_length", out_length, e.len);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    initial begin
        int seen;
        tv[0]  = mk(msb(48'b10, 2),           1, 1,        2,  0, 0);
        tv[1]  = mk(msb(48'b0011, 4),         0, -3,       4,  0, 0);
        tv[2]  = mk(msb(48'b0000010000, 10),  0, 10,       10, 0, 5);
        tv[3]  = mk(msb(48'b1001, 4),         0, -1,       4,  0, 0);
        tv[4]  = mk(msb(48'b0001001, 7),      0, -4,       7,  0, 0);
        tv[5]  = mk(msb(48'b00111, 5),        1, -4,       5,  0, 0);
        tv[6]  = mk(msb(48'b11, 2),           0, -1,       2,  0, 0);
        tv[7]  = mk(48'd0,                    0, 0,        0,  1, 0);
        tv[8]  = mk(48'd1,                    0, 0,        0,  1, 0);
        tv[9]  = mk(msb(48'b0011, 4),         0, -3,       4,  0, 0);
        tv[10] = mk(msb(48'b000110, 6),       0, 5,        6,  0, 0);
        tv[11] = mk(msb(48'b01010, 5),        0, 4,        5,  0, 0);
        tv[12] = mk((48'd1 << 24) | 48'd1,    0, -8388608, 48, 0, 0);
        tv[13] = mk(msb(48'b1000, 4),         0, 1,        4,  0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_level", out_level, 0);
        chk("rst_length", out_length, 0);
        chk("rst_error", out_error, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            send(tv[i].win, tv[i].bs, tv[i].level, tv[i].len, tv[i].err, tv[i].hold);
        end

        @(negedge clk);
        in_window   = msb(48'b0011, 4);
        block_start = 1'b0;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        chk("abort_no_output", seen, 0);
        send(msb(48'b0011, 4), 0, 4, 5, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
